// File: rtl/mem_port_arbiter.sv
// Two-port memory request arbiter with outstanding tracking and drain fence.
//
// The I-cache and D-cache request ports share one downstream memory request
// channel. Each accepted request is registered once and presented downstream
// with one cycle of latency. The registered tid carries the source in its MSB
// (0 = I-cache, 1 = D-cache) so responses can be routed back, also through a
// register stage.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   icache_req_*                  I-cache read requests (valid/ready/addr/tid)
//   dcache_req_*                  D-cache requests (valid/ready/addr/tid/we/wdata)
//   mem_req_*                     shared downstream request (valid/ready/payload)
//   mem_rsp_*                     downstream response, no backpressure
//   icache_rsp_*, dcache_rsp_*    routed, registered responses
//   drain_req_i / drain_done_o    fence request level / one-cycle completion pulse

// Simulation-only checks on the arbiter's internal bookkeeping.
module mem_port_arbiter_checker #(
    parameter int CntWidth = 3
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic                i_dec,
    input logic                d_dec,
    input logic [CntWidth-1:0] i_cnt,
    input logic [CntWidth-1:0] d_cnt,
    input logic                i_grant,
    input logic                d_grant
);
    a_i_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(i_dec && (i_cnt == '0)))
        else $error("icache outstanding counter underflow");

    a_d_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(d_dec && (d_cnt == '0)))
        else $error("dcache outstanding counter underflow");

    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(i_grant && d_grant))
        else $error("both request ports granted in one cycle");
endmodule

module mem_port_arbiter #(
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int MemTidWidth    = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   icache_req_valid_i,
    output logic                   icache_req_ready_o,
    input  logic [AddrWidth-1:0]   icache_req_addr_i,
    input  logic [MemTidWidth-1:0] icache_req_tid_i,
    input  logic                   dcache_req_valid_i,
    output logic                   dcache_req_ready_o,
    input  logic [AddrWidth-1:0]   dcache_req_addr_i,
    input  logic [MemTidWidth-1:0] dcache_req_tid_i,
    input  logic                   dcache_req_we_i,
    input  logic [DataWidth-1:0]   dcache_req_wdata_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [AddrWidth-1:0]   mem_req_addr_o,
    output logic                   mem_req_we_o,
    output logic [DataWidth-1:0]   mem_req_wdata_o,
    output logic [MemTidWidth:0]   mem_req_tid_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [MemTidWidth:0]   mem_rsp_tid_i,
    input  logic [DataWidth-1:0]   mem_rsp_rdata_i,
    output logic                   icache_rsp_valid_o,
    output logic [MemTidWidth-1:0] icache_rsp_tid_o,
    output logic [DataWidth-1:0]   icache_rsp_rdata_o,
    output logic                   dcache_rsp_valid_o,
    output logic [MemTidWidth-1:0] dcache_rsp_tid_o,
    output logic [DataWidth-1:0]   dcache_rsp_rdata_o,
    input  logic                   drain_req_i,
    output logic                   drain_done_o
);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } drain_state_e;

    drain_state_e state_r, state_next_s;

    logic                   rr_r;           // 1: D-cache wins the next tie
    logic [CntWidth-1:0]    i_cnt_r, d_cnt_r;
    logic                   out_valid_r;
    logic [AddrWidth-1:0]   out_addr_r;
    logic                   out_we_r;
    logic [DataWidth-1:0]   out_wdata_r;
    logic [MemTidWidth:0]   out_tid_r;
    logic                   i_rsp_valid_r, d_rsp_valid_r;
    logic [MemTidWidth-1:0] i_rsp_tid_r, d_rsp_tid_r;
    logic [DataWidth-1:0]   i_rsp_rdata_r, d_rsp_rdata_r;
    logic                   drain_done_r;

    logic out_free_s, i_elig_s, d_elig_s, i_grant_s, d_grant_s;
    logic i_rsp_hit_s, d_rsp_hit_s, all_empty_s;

    // Saturating-at-zero counter step; simultaneous inc/dec holds the value.
    function automatic logic [CntWidth-1:0] cnt_next(input logic [CntWidth-1:0] cnt,
                                                     input logic inc, input logic dec);
        logic [CntWidth-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CntWidth'(1'b1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CntWidth'(1'b1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Eligibility and round-robin grant selection.
    always_comb begin
        out_free_s = !out_valid_r || mem_req_ready_i;
        i_elig_s   = icache_req_valid_i && (i_cnt_r < CntMax) &&
                     (state_r == ST_IDLE) && out_free_s;
        d_elig_s   = dcache_req_valid_i && (d_cnt_r < CntMax) &&
                     (state_r == ST_IDLE) && out_free_s;
        if (i_elig_s && d_elig_s) begin
            i_grant_s = !rr_r;
            d_grant_s = rr_r;
        end else begin
            i_grant_s = i_elig_s;
            d_grant_s = d_elig_s;
        end
    end

    assign icache_req_ready_o = i_grant_s;
    assign dcache_req_ready_o = d_grant_s;

    assign i_rsp_hit_s = mem_rsp_valid_i && !mem_rsp_tid_i[MemTidWidth];
    assign d_rsp_hit_s = mem_rsp_valid_i &&  mem_rsp_tid_i[MemTidWidth];
    assign all_empty_s = (i_cnt_r == '0) && (d_cnt_r == '0) && !out_valid_r;

    // Drain FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (drain_req_i) state_next_s = ST_DRAIN;
                else             state_next_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!drain_req_i)     state_next_s = ST_IDLE;
                else if (all_empty_s) state_next_s = ST_DONE;
                else                  state_next_s = ST_DRAIN;
            end
            ST_DONE: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (!drain_req_i) state_next_s = ST_IDLE;
                else              state_next_s = ST_HOLD;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Drain FSM state register and registered completion pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            drain_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            drain_done_r <= (state_next_s == ST_DONE);
        end
    end

    // Outstanding counters and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_cnt_r <= '0;
            d_cnt_r <= '0;
            rr_r    <= 1'b1;
        end else begin
            i_cnt_r <= cnt_next(i_cnt_r, i_grant_s, i_rsp_hit_s);
            d_cnt_r <= cnt_next(d_cnt_r, d_grant_s, d_rsp_hit_s);
            if (i_elig_s && d_elig_s) rr_r <= !rr_r;
        end
    end

    // Downstream output register: capture a grant, else retire on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_we_r    <= 1'b0;
            out_wdata_r <= '0;
            out_tid_r   <= '0;
        end else if (i_grant_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= icache_req_addr_i;
            out_we_r    <= 1'b0;
            out_wdata_r <= '0;
            out_tid_r   <= {1'b0, icache_req_tid_i};
        end else if (d_grant_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= dcache_req_addr_i;
            out_we_r    <= dcache_req_we_i;
            out_wdata_r <= dcache_req_wdata_i;
            out_tid_r   <= {1'b1, dcache_req_tid_i};
        end else if (mem_req_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    // Response routing registers, steered by the tid source bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_rsp_valid_r <= 1'b0;
            i_rsp_tid_r   <= '0;
            i_rsp_rdata_r <= '0;
            d_rsp_valid_r <= 1'b0;
            d_rsp_tid_r   <= '0;
            d_rsp_rdata_r <= '0;
        end else begin
            i_rsp_valid_r <= i_rsp_hit_s;
            d_rsp_valid_r <= d_rsp_hit_s;
            if (i_rsp_hit_s) begin
                i_rsp_tid_r   <= mem_rsp_tid_i[MemTidWidth-1:0];
                i_rsp_rdata_r <= mem_rsp_rdata_i;
            end
            if (d_rsp_hit_s) begin
                d_rsp_tid_r   <= mem_rsp_tid_i[MemTidWidth-1:0];
                d_rsp_rdata_r <= mem_rsp_rdata_i;
            end
        end
    end

    assign mem_req_valid_o    = out_valid_r;
    assign mem_req_addr_o     = out_addr_r;
    assign mem_req_we_o       = out_we_r;
    assign mem_req_wdata_o    = out_wdata_r;
    assign mem_req_tid_o      = out_tid_r;
    assign icache_rsp_valid_o = i_rsp_valid_r;
    assign icache_rsp_tid_o   = i_rsp_tid_r;
    assign icache_rsp_rdata_o = i_rsp_rdata_r;
    assign dcache_rsp_valid_o = d_rsp_valid_r;
    assign dcache_rsp_tid_o   = d_rsp_tid_r;
    assign dcache_rsp_rdata_o = d_rsp_rdata_r;
    assign drain_done_o       = drain_done_r;

    mem_port_arbiter_checker #(.CntWidth(CntWidth)) u_checker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_dec   (i_rsp_hit_s),
        .d_dec   (d_rsp_hit_s),
        .i_cnt   (i_cnt_r),
        .d_cnt   (d_cnt_r),
        .i_grant (i_grant_s),
        .d_grant (d_grant_s)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model every cycle.
module tb_mem_port_arbiter;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int TW   = 2;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          iv, dv, dwe, mready, rv, drain;
    logic [AW-1:0] iaddr, daddr;
    logic [TW-1:0] itid, dtid;
    logic [DW-1:0] dwdata, rdata;
    logic [TW:0]   rtid;

    logic          i_ready, d_ready, m_valid, m_we, i_rv, d_rv, done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, i_rdata, d_rdata;
    logic [TW:0]   m_tid;
    logic [TW-1:0] i_rtid, d_rtid;

    mem_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MemTidWidth(TW),
                       .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .icache_req_valid_i(iv), .icache_req_ready_o(i_ready),
        .icache_req_addr_i(iaddr), .icache_req_tid_i(itid),
        .dcache_req_valid_i(dv), .dcache_req_ready_o(d_ready),
        .dcache_req_addr_i(daddr), .dcache_req_tid_i(dtid),
        .dcache_req_we_i(dwe), .dcache_req_wdata_i(dwdata),
        .mem_req_valid_o(m_valid), .mem_req_ready_i(mready),
        .mem_req_addr_o(m_addr), .mem_req_we_o(m_we),
        .mem_req_wdata_o(m_wdata), .mem_req_tid_o(m_tid),
        .mem_rsp_valid_i(rv), .mem_rsp_tid_i(rtid), .mem_rsp_rdata_i(rdata),
        .icache_rsp_valid_o(i_rv), .icache_rsp_tid_o(i_rtid), .icache_rsp_rdata_o(i_rdata),
        .dcache_rsp_valid_o(d_rv), .dcache_rsp_tid_o(d_rtid), .dcache_rsp_rdata_o(d_rdata),
        .drain_req_i(drain), .drain_done_o(done)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [TW:0]   tid;
    } req_t;

    // Reference model state
    req_t        slot_q[$];      // request waiting downstream (0 or 1 entries)
    logic [TW:0] pool_q[$];      // requests issued downstream, awaiting response
    int          icnt, dcnt;
    bit          pref_d;
    int          phase;          // 0 normal, 1 draining, 2 done pulse, 3 holding
    bit          e_irv, e_drv;
    logic [TW-1:0] e_itid, e_dtid;
    logic [DW-1:0] e_irdata, e_drdata;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        slot_q.delete();
        pool_q.delete();
        icnt = 0; dcnt = 0; pref_d = 1'b1; phase = 0;
        e_irv = 1'b0; e_drv = 1'b0;
        e_itid = '0; e_dtid = '0; e_irdata = '0; e_drdata = '0;
    endtask

    // Compare DUT against model for this cycle, then advance the model past the edge.
    task automatic model_step();
        bit free, ei, ed, gi, gd, empty_now;
        req_t r;
        free = (slot_q.size() == 0) || mready;
        ei = iv && (icnt < MAXO) && (phase == 0) && free;
        ed = dv && (dcnt < MAXO) && (phase == 0) && free;
        gi = ei && (!ed || !pref_d);
        gd = ed && (!ei || pref_d);
        chk("i_ready", i_ready, gi);
        chk("d_ready", d_ready, gd);
        chk("mem_valid", m_valid, slot_q.size() != 0);
        if (slot_q.size() != 0) begin
            chk("mem_addr", m_addr, slot_q[0].addr);
            chk("mem_we", m_we, slot_q[0].we);
            chk("mem_wdata", m_wdata, slot_q[0].wdata);
            chk("mem_tid", m_tid, slot_q[0].tid);
        end
        chk("i_rsp_valid", i_rv, e_irv);
        chk("d_rsp_valid", d_rv, e_drv);
        if (e_irv) begin
            chk("i_rsp_tid", i_rtid, e_itid);
            chk("i_rsp_rdata", i_rdata, e_irdata);
        end
        if (e_drv) begin
            chk("d_rsp_tid", d_rtid, e_dtid);
            chk("d_rsp_rdata", d_rdata, e_drdata);
        end
        chk("drain_done", done, phase == 2);
        chk("i_count", dut.i_cnt_r, icnt);
        chk("d_count", dut.d_cnt_r, dcnt);

        empty_now = (icnt == 0) && (dcnt == 0) && (slot_q.size() == 0);
        if ((slot_q.size() != 0) && mready) begin
            pool_q.push_back(slot_q[0].tid);
            slot_q.pop_front();
        end
        if (gi) begin
            r.addr = iaddr; r.we = 1'b0; r.wdata = '0; r.tid = {1'b0, itid};
            slot_q.push_back(r);
            icnt++;
        end
        if (gd) begin
            r.addr = daddr; r.we = dwe; r.wdata = dwdata; r.tid = {1'b1, dtid};
            slot_q.push_back(r);
            dcnt++;
        end
        if (ei && ed) pref_d = !pref_d;
        e_irv = rv && !rtid[TW];
        e_drv = rv && rtid[TW];
        if (e_irv) begin
            e_itid = rtid[TW-1:0]; e_irdata = rdata;
            if (icnt > 0) icnt--;
        end
        if (e_drv) begin
            e_dtid = rtid[TW-1:0]; e_drdata = rdata;
            if (dcnt > 0) dcnt--;
        end
        case (phase)
            0: if (drain) phase = 1;
            1: if (!drain) phase = 0; else if (empty_now) phase = 2;
            2: phase = 3;
            default: if (!drain) phase = 0;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        rv = 1'b0;
    endtask

    task automatic pick_rsp(input int idx);
        rv    = 1'b1;
        rtid  = pool_q[idx];
        rdata = {$urandom(), $urandom()};
        pool_q.delete(idx);
    endtask

    task automatic take_rsp(input logic [TW:0] tid, input logic [DW-1:0] data);
        int idx;
        idx = -1;
        for (int k = 0; k < pool_q.size(); k++) if (pool_q[k] == tid && idx < 0) idx = k;
        if (idx >= 0) pool_q.delete(idx);
        rv = 1'b1; rtid = tid; rdata = data;
    endtask

    // Retire everything outstanding, bounded; the DUT counters must reach zero.
    task automatic settle();
        iv = 1'b0; dv = 1'b0; mready = 1'b1; drain = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (pool_q.size() > 0) pick_rsp(0);
            if (pool_q.size() == 0 && slot_q.size() == 0 && icnt == 0 && dcnt == 0
                && phase == 0 && !rv) break;
            tick();
        end
        chk("settle_i_count", dut.i_cnt_r, 0);
        chk("settle_d_count", dut.d_cnt_r, 0);
    endtask

    initial begin
        iv = 1'b0; dv = 1'b0; dwe = 1'b0; mready = 1'b0; rv = 1'b0; drain = 1'b0;
        iaddr = '0; daddr = '0; itid = '0; dtid = '0; dwdata = '0; rdata = '0; rtid = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_valid", m_valid, 0);
        chk("rst_mem_addr", m_addr, 0);
        chk("rst_rsp_valid", {i_rv, d_rv}, 0);
        chk("rst_drain_done", done, 0);
        chk("rst_ready", {i_ready, d_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both ports saturate: D,I,D,I,... then no grants at the limit
        for (int k = 0; k < 10; k++) begin
            iv = 1'b1; dv = 1'b1; mready = 1'b1;
            itid = TW'(k); dtid = TW'(k + 1);
            iaddr = 64'h1000 + AW'(k); daddr = 64'h2000 + AW'(k);
            dwe = 1'b0; dwdata = 64'h55 + DW'(k);
            #1;
            chk("rr_d_grant", d_ready, (k < 8) && (k % 2 == 0));
            chk("rr_i_grant", i_ready, (k < 8) && (k % 2 == 1));
            tick();
        end
        settle();

        // D-cache write stalls downstream for five cycles
        iv = 1'b0; dv = 1'b1; dwe = 1'b1; daddr = 64'h8000_0000;
        dwdata = 64'hDEAD_BEEF; dtid = 2'b10; mready = 1'b0;
        #1;
        chk("stall_accept", d_ready, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            iv = 1'b1; dv = 1'b1; dwe = 1'b0; daddr = 64'h4444; mready = 1'b0;
            #1;
            chk("stall_no_ready", {i_ready, d_ready}, 0);
            chk("stall_addr", m_addr, 64'h8000_0000);
            chk("stall_wdata", m_wdata, 64'hDEAD_BEEF);
            chk("stall_we", m_we, 1);
            chk("stall_tid", m_tid, 3'b110);
            tick();
        end
        iv = 1'b0; dv = 1'b0; mready = 1'b1;
        tick();

        // Response routed to D-cache one cycle later
        take_rsp(3'b110, 64'h1234);
        tick();
        chk("rsp_d_valid", d_rv, 1);
        chk("rsp_d_tid", d_rtid, 2'b10);
        chk("rsp_d_rdata", d_rdata, 64'h1234);
        chk("rsp_i_quiet", i_rv, 0);
        chk("rsp_d_count", dut.d_cnt_r, 0);
        settle();

        // Simultaneous D-cache handshake and D-cache response at count 2
        dv = 1'b1; dwe = 1'b0; dtid = 2'd0; mready = 1'b1; tick();
        dv = 1'b1; dtid = 2'd1; tick();
        chk("same_pre_count", dut.d_cnt_r, 2);
        dv = 1'b1; dtid = 2'd2; take_rsp(3'b100, 64'hABCD);
        tick();
        chk("same_hold_count", dut.d_cnt_r, 2);
        settle();

        // Drain with two I-cache requests outstanding
        iv = 1'b1; itid = 2'd0; iaddr = 64'h100; mready = 1'b1; tick();
        iv = 1'b1; itid = 2'd1; iaddr = 64'h104; tick();
        iv = 1'b0; tick();
        for (int k = 0; k < 15; k++) begin
            drain = (k < 13);
            iv = (k >= 1); dv = (k >= 1) && (k < 14);
            if ((k == 3 || k == 6) && pool_q.size() > 0) pick_rsp(0);
            #1;
            chk("drain_pulse", done, k == 8);
            if (k >= 1 && k <= 13) chk("drain_no_ready", {i_ready, d_ready}, 0);
            if (k == 14) chk("drain_resume", i_ready, 1);
            tick();
        end
        settle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            iv = ($urandom_range(0, 1) == 1);
            dv = ($urandom_range(0, 1) == 1);
            dwe = ($urandom_range(0, 1) == 1);
            iaddr = {$urandom(), $urandom()};
            daddr = {$urandom(), $urandom()};
            dwdata = {$urandom(), $urandom()};
            itid = TW'($urandom_range(0, 3));
            dtid = TW'($urandom_range(0, 3));
            mready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) drain = !drain;
            if (pool_q.size() > 0 && $urandom_range(0, 2) == 0)
                pick_rsp(int'($urandom_range(0, pool_q.size() - 1)));
            tick();
        end
        settle();

        // Reset in the middle of a burst
        for (int k = 0; k < 3; k++) begin
            iv = 1'b1; dv = 1'b1; mready = 1'b1; dwe = 1'b1;
            iaddr = 64'h9000 + AW'(k); daddr = 64'hA000 + AW'(k);
            tick();
        end
        chk("burst_valid", m_valid, 1);
        rst_n = 1'b0; iv = 1'b0; dv = 1'b0;
        #1;
        chk("arst_mem_valid", m_valid, 0);
        chk("arst_mem_payload", {m_addr, m_wdata}, 0);
        chk("arst_mem_we_tid", {m_we, m_tid}, 0);
        chk("arst_rsp_valid", {i_rv, d_rv}, 0);
        chk("arst_drain_done", done, 0);
        chk("arst_ready", {i_ready, d_ready}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("arst_i_count", dut.i_cnt_r, 0);
        chk("arst_d_count", dut.d_cnt_r, 0);
        for (int k = 0; k < 6; k++) begin
            iv = 1'b1; dv = (k % 2 == 0); mready = 1'b1;
            tick();
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
